// File: rtl/store_wbuf_pkg.sv
// Shared types and constants for the posted-store write buffer.
// The entry struct is sized from WB_ADDR_W/WB_DATA_W; the top-level ADDR_W/DATA_W
// parameters are expected to match these values.
package store_wbuf_pkg;

    localparam int WB_ADDR_W   = 32;
    localparam int WB_DATA_W   = 32;
    localparam int WB_WORD_LSB = 2;

    typedef struct packed {
        logic [WB_ADDR_W-3:0] word_addr;
        logic [WB_DATA_W-1:0] data;
    } wbuf_entry_t;

    typedef enum logic [1:0] {
        WB_RUN   = 2'd0,
        WB_DRAIN = 2'd1,
        WB_DONE  = 2'd2
    } wbuf_state_e;

    // Word-granular address comparison used by load-hit and merge detection.
    function automatic logic word_match(input logic [WB_ADDR_W-3:0] a,
                                        input logic [WB_ADDR_W-3:0] b);
        return (a == b);
    endfunction

endpackage

// File: rtl/store_wbuf_ram.sv
// Entry storage for the store write buffer: one write port, one asynchronous
// head read port and parallel word-address comparators across all entries.
// Optional macro STORE_WBUF_MERGE_EN adds a second comparator vector for store merging.
module store_wbuf_ram
    import store_wbuf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [PTR_W-1:0]     waddr,
    input  wbuf_entry_t          wdata,
    input  logic [PTR_W-1:0]     raddr,
    output wbuf_entry_t          rdata,
    input  logic [WB_ADDR_W-3:0] ld_word,
    output logic [DEPTH-1:0]     ld_match
`ifdef STORE_WBUF_MERGE_EN
    ,
    input  logic [WB_ADDR_W-3:0] st_word,
    output logic [DEPTH-1:0]     st_match
`endif
);

    wbuf_entry_t entries_r [DEPTH];

    // Entry write; contents need no reset since occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (we) begin
            entries_r[waddr] <= wdata;
        end
    end

    assign rdata = entries_r[raddr];

    // Compare every entry against the load word address.
    always_comb begin
        ld_match = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            ld_match[i] = word_match(entries_r[i].word_addr, ld_word);
        end
    end

`ifdef STORE_WBUF_MERGE_EN
    // Compare every entry against the incoming store word address.
    always_comb begin
        st_match = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            st_match[i] = word_match(entries_r[i].word_addr, st_word);
        end
    end
`endif

endmodule

// File: rtl/store_write_buffer.sv
// Posted-store write buffer between the MEM stage and the external data bus.
// Stores are queued in a FIFO and drained over a valid/ready handshake; a flush
// request drains the buffer and pulses flush_done; load-address hazards are flagged.
// Optional macro STORE_WBUF_MERGE_EN: same-word stores merge into the newest entry.
module store_write_buffer
    import store_wbuf_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DATA_W = WB_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_valid,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              st_stall,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_hit,
    input  logic              flush_req,
    output logic              flush_done,
    output logic              bus_valid,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_data,
    input  logic              bus_ready
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] newest_ptr_s;
    logic [PTR_W-1:0] waddr_s;
    logic [PTR_W-1:0] offs_s [DEPTH];
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    wbuf_state_e      state_r;
    wbuf_state_e      state_nxt_s;
    logic             bus_valid_r;
    logic             flush_done_r;
    logic             pop_s;
    logic             push_s;
    logic             alloc_s;
    logic             merge_s;
    logic             full_s;
    logic             run_s;
    logic             stall_s;
    wbuf_entry_t      wentry_s;
    wbuf_entry_t      head_s;
    logic [DEPTH-1:0] ld_match_s;
    logic [DEPTH-1:0] occ_s;
    logic             unused_addr_bits_s;
`ifdef STORE_WBUF_MERGE_EN
    logic [DEPTH-1:0] st_match_s;
`endif

    // The byte-offset bits never take part in word matching.
    assign unused_addr_bits_s = ^{st_addr[WB_WORD_LSB-1:0], ld_addr[WB_WORD_LSB-1:0]};

    assign run_s        = (state_r == WB_RUN);
    assign full_s       = (count_r == CNT_FULL);
    assign pop_s        = bus_valid_r && bus_ready;
    assign newest_ptr_s = wr_ptr_r - PTR_ONE;

`ifdef STORE_WBUF_MERGE_EN
    // Merge into the newest entry unless that entry is the head leaving this cycle.
    assign merge_s = st_valid && run_s && (count_r != CNT_ZERO) &&
                     st_match_s[newest_ptr_s] && !((count_r == CNT_ONE) && pop_s);
`else
    assign merge_s = 1'b0;
`endif

    assign stall_s = st_valid && (!run_s || (full_s && !pop_s && !merge_s));
    assign push_s  = st_valid && !stall_s;
    assign alloc_s = push_s && !merge_s;
    assign waddr_s = merge_s ? newest_ptr_s : wr_ptr_r;

    assign wentry_s.word_addr = st_addr[ADDR_W-1:WB_WORD_LSB];
    assign wentry_s.data      = st_data;

    store_wbuf_ram #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk      (clk),
        .we       (push_s),
        .waddr    (waddr_s),
        .wdata    (wentry_s),
        .raddr    (rd_ptr_r),
        .rdata    (head_s),
        .ld_word  (ld_addr[ADDR_W-1:WB_WORD_LSB]),
        .ld_match (ld_match_s)
`ifdef STORE_WBUF_MERGE_EN
        ,
        .st_word  (st_addr[ADDR_W-1:WB_WORD_LSB]),
        .st_match (st_match_s)
`endif
    );

    // Occupancy mask: entry i is live when its distance from the head is below count.
    always_comb begin
        occ_s = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            offs_s[i] = PTR_W'(i) - rd_ptr_r;
            occ_s[i]  = ({1'b0, offs_s[i]} < count_r);
        end
    end

    // Occupancy count follows allocations and pops; merges do not allocate.
    always_comb begin
        count_nxt_s = count_r;
        case ({alloc_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Flush sequencing: drain until empty, then announce completion for one cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            WB_RUN: begin
                if (flush_req) begin
                    state_nxt_s = WB_DRAIN;
                end else begin
                    state_nxt_s = WB_RUN;
                end
            end
            WB_DRAIN: begin
                if ((count_r == CNT_ZERO) || ((count_r == CNT_ONE) && pop_s)) begin
                    state_nxt_s = WB_DONE;
                end else begin
                    state_nxt_s = WB_DRAIN;
                end
            end
            WB_DONE: state_nxt_s = WB_RUN;
            default: state_nxt_s = WB_RUN;
        endcase
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= CNT_ZERO;
        end else begin
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (alloc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
        end
    end

    // FSM state and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= WB_RUN;
            bus_valid_r  <= 1'b0;
            flush_done_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            bus_valid_r  <= (count_nxt_s != CNT_ZERO);
            flush_done_r <= (state_nxt_s == WB_DONE);
        end
    end

    // Head presentation to the bus; zeroed when nothing is offered.
    always_comb begin
        if (bus_valid_r) begin
            bus_addr = {head_s.word_addr, 2'b00};
            bus_data = head_s.data;
        end else begin
            bus_addr = {ADDR_W{1'b0}};
            bus_data = {DATA_W{1'b0}};
        end
    end

    assign bus_valid  = bus_valid_r;
    assign flush_done = flush_done_r;
    assign st_stall   = stall_s;
    assign ld_hit     = ld_valid && (|(ld_match_s & occ_s));

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: a queue-based reference model is
// compared against the DUT on every cycle, alongside directed literal checks.
module tb_store_write_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_stall;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic        flush_req;
    logic        flush_done;
    logic        bus_valid;
    logic [31:0] bus_addr;
    logic [31:0] bus_data;
    logic        bus_ready;

    int vectors     = 0;
    int miscompares = 0;

    store_write_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .st_valid   (st_valid),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .st_stall   (st_stall),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .ld_hit     (ld_hit),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .bus_valid  (bus_valid),
        .bus_addr   (bus_addr),
        .bus_data   (bus_data),
        .bus_ready  (bus_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [29:0] w;
        logic [31:0] d;
    } ment_t;

    ment_t mq[$];
    bit    m_flushing = 1'b0;
    bit    m_done     = 1'b0;
    bit    started    = 1'b0;

    function automatic bit m_pop();
        return (mq.size() != 0) && bus_ready;
    endfunction

    function automatic bit m_merge();
`ifdef STORE_WBUF_MERGE_EN
        if (!st_valid || mq.size() == 0 || m_flushing || m_done) return 1'b0;
        if (mq[mq.size()-1].w != st_addr[31:2]) return 1'b0;
        if (mq.size() == 1 && bus_ready) return 1'b0;
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_stall();
        return st_valid && (m_flushing || m_done ||
                            (mq.size() == DEPTH && !m_pop() && !m_merge()));
    endfunction

    function automatic bit m_ld_hit();
        if (!ld_valid) return 1'b0;
        foreach (mq[i]) if (mq[i].w == ld_addr[31:2]) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin : model_update
        bit pop_m, merge_m, acc_m;
        if (!rst_n) begin
            mq.delete();
            m_flushing = 1'b0;
            m_done     = 1'b0;
            started    = 1'b1;
        end else begin
            pop_m   = m_pop();
            merge_m = m_merge();
            acc_m   = st_valid && !m_stall();
            if (m_done) begin
                m_done = 1'b0;
            end else if (m_flushing) begin
                if (mq.size() == 0 || (mq.size() == 1 && pop_m)) begin
                    m_flushing = 1'b0;
                    m_done     = 1'b1;
                end
            end else if (flush_req) begin
                m_flushing = 1'b1;
            end
            if (pop_m) void'(mq.pop_front());
            if (acc_m) begin
                if (merge_m) mq[mq.size()-1].d = st_data;
                else         mq.push_back(ment_t'{w: st_addr[31:2], d: st_data});
            end
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (started) begin
            chk("bus_valid",  {31'd0, bus_valid},  {31'd0, mq.size() != 0});
            chk("bus_addr",   bus_addr,  (mq.size() != 0) ? {mq[0].w, 2'b00} : 32'd0);
            chk("bus_data",   bus_data,  (mq.size() != 0) ? mq[0].d : 32'd0);
            chk("st_stall",   {31'd0, st_stall},   {31'd0, m_stall()});
            chk("ld_hit",     {31'd0, ld_hit},     {31'd0, m_ld_hit()});
            chk("flush_done", {31'd0, flush_done}, {31'd0, m_done});
        end
    end

    // Record what the bus actually drains and count flush_done pulses.
    logic [31:0] drained_a[$];
    logic [31:0] drained_d[$];
    int          fd_count = 0;
    always @(negedge clk) begin
        if (bus_valid && bus_ready) begin
            drained_a.push_back(bus_addr);
            drained_d.push_back(bus_data);
        end
        if (flush_done) fd_count++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        step();
        st_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int pulses;
        int done_at;
        int fd_before;

        rst_n = 1'b0; st_valid = 1'b0; st_addr = 32'd0; st_data = 32'd0;
        ld_valid = 1'b0; ld_addr = 32'd0; flush_req = 1'b0; bus_ready = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("reset_bus_valid", {31'd0, bus_valid}, 32'd0);
        chk("reset_bus_addr", bus_addr, 32'd0);
        chk("reset_flush_done", {31'd0, flush_done}, 32'd0);
        step();
        rst_n = 1'b1;

        // Test 1: single store, immediate pop
        bus_ready = 1'b1;
        st_valid = 1'b1; st_addr = 32'h100; st_data = 32'hAA;
        @(negedge clk);
        chk("t1_stall", {31'd0, st_stall}, 32'd0);
        step();
        st_valid = 1'b0;
        @(negedge clk);
        chk("t1_valid", {31'd0, bus_valid}, 32'd1);
        chk("t1_addr", bus_addr, 32'h100);
        chk("t1_data", bus_data, 32'hAA);
        step();
        @(negedge clk);
        chk("t1_empty", {31'd0, bus_valid}, 32'd0);

        // Test 2: fill, stall on fifth, accept with first pop
        step();
        bus_ready = 1'b0;
        drained_a.delete(); drained_d.delete();
        for (int i = 0; i < 4; i++) push_one(32'(i * 4), 32'(i + 16));
        st_valid = 1'b1; st_addr = 32'h10; st_data = 32'h14;
        @(negedge clk);
        chk("t2_full_stall", {31'd0, st_stall}, 32'd1);
        step();
        @(negedge clk);
        chk("t2_full_stall2", {31'd0, st_stall}, 32'd1);
        step();
        bus_ready = 1'b1;
        @(negedge clk);
        chk("t2_pop_accept", {31'd0, st_stall}, 32'd0);
        step();
        st_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("t2_drain_count", 32'(drained_a.size()), 32'd5);
        for (int i = 0; i < 5 && i < drained_a.size(); i++) begin
            chk("t2_order", drained_a[i], 32'(i * 4));
        end

        // Test 3: load hazards
        bus_ready = 1'b0;
        push_one(32'h200, 32'h5);
        ld_valid = 1'b1; ld_addr = 32'h202;
        @(negedge clk);
        chk("t3_hit_same_word", {31'd0, ld_hit}, 32'd1);
        step();
        ld_addr = 32'h204;
        @(negedge clk);
        chk("t3_miss_next_word", {31'd0, ld_hit}, 32'd0);
        step();
        bus_ready = 1'b1; ld_addr = 32'h202;
        @(negedge clk);
        chk("t3_hit_before_pop", {31'd0, ld_hit}, 32'd1);
        step();
        @(negedge clk);
        chk("t3_miss_after_drain", {31'd0, ld_hit}, 32'd0);
        step();
        ld_valid = 1'b0;

        // Test 4a: flush with three entries
        bus_ready = 1'b0;
        push_one(32'h300, 32'h30);
        push_one(32'h304, 32'h31);
        push_one(32'h308, 32'h32);
        bus_ready = 1'b1; flush_req = 1'b1;
        pulses = 0; done_at = -1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (flush_done) begin pulses++; done_at = k; end
            if (k >= 1 && k <= 3) chk("t4_stall_during_flush", {31'd0, st_stall}, 32'd1);
            step();
            if (k == 0) begin
                flush_req = 1'b0; st_valid = 1'b1; st_addr = 32'h400; st_data = 32'h44;
            end
            if (k == 4) st_valid = 1'b0;
        end
        chk("t4_pulse_count", 32'(pulses), 32'd1);
        chk("t4_pulse_cycle", 32'(done_at), 32'd3);

        // Test 4b: flush of empty buffer
        flush_req = 1'b1;
        pulses = 0; done_at = -1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (flush_done) begin pulses++; done_at = k; end
            step();
            if (k == 0) flush_req = 1'b0;
        end
        chk("t4_empty_pulses", 32'(pulses), 32'd1);
        chk("t4_empty_cycle", 32'(done_at), 32'd2);

        // Test 5: reset in the middle of a drain
        bus_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_one(32'h500 + 32'(i * 4), 32'(i + 80));
        fd_before = fd_count;
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        step();
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_valid_before_rst", {31'd0, bus_valid}, 32'd1);
        step();
        rst_n = 1'b1;
        st_valid = 1'b1; st_addr = 32'h600; st_data = 32'h66;
        @(negedge clk);
        chk("t5_valid_after_rst", {31'd0, bus_valid}, 32'd0);
        chk("t5_stall_after_rst", {31'd0, st_stall}, 32'd0);
        step();
        st_valid = 1'b0;
        @(negedge clk);
        chk("t5_new_head_addr", bus_addr, 32'h600);
        chk("t5_new_head_data", bus_data, 32'h66);
        for (int i = 0; i < 4; i++) step();
        chk("t5_no_flush_done", 32'(fd_count - fd_before), 32'd0);
        bus_ready = 1'b1;
        step();
        step();

        // Test 6: same-word stores
        bus_ready = 1'b0;
        push_one(32'h40, 32'h1);
        push_one(32'h40, 32'h2);
        @(negedge clk);
`ifdef STORE_WBUF_MERGE_EN
        chk("t6_head_data", bus_data, 32'h2);
`else
        chk("t6_head_data", bus_data, 32'h1);
`endif
        step();
        drained_a.delete(); drained_d.delete();
        bus_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
`ifdef STORE_WBUF_MERGE_EN
        chk("t6_drain_count", 32'(drained_d.size()), 32'd1);
        if (drained_d.size() > 0) chk("t6_drain0", drained_d[0], 32'h2);
`else
        chk("t6_drain_count", 32'(drained_d.size()), 32'd2);
        if (drained_d.size() > 1) begin
            chk("t6_drain0", drained_d[0], 32'h1);
            chk("t6_drain1", drained_d[1], 32'h2);
        end
`endif
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
